// File: rtl/qspi_host_master.sv
// qspi_host_master: Wishbone-slave to QSPI-master engine.
// Each accepted 16-bit Wishbone access becomes one QSPI frame:
//   CMD (8 single-bit SCK cycles) -> ADDR (8 quad) -> DUMMY (reads only)
//   -> DATA (4 quad) -> HOLD (SCK low) -> CE# high, ack -> GAP.
// Ports:
//   clk_i, reset_i            : clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i       : Wishbone pipelined request
//   wb_adr_i, wb_dat_i        : word address, write data
//   wb_dat_o, wb_ack_o        : read data (valid with ack), completion pulse
//   wb_stall_o, wb_err_o      : busy indication, error (always 0)
//   spi_sck_o, spi_sce_o      : SCK (mode 0), CE# (active low)
//   spi_io_o, spi_io_oe       : IO output lanes and per-lane output enables
//   spi_io_i                  : IO input lanes
module qspi_host_master #(
  parameter int unsigned ADDRBITS = 26,
  parameter int unsigned DATABITS = 16,
  parameter int unsigned CLKDIV   = 2,
  parameter int unsigned DUMMY    = 4,
  parameter logic [7:0]  CMD_RD   = 8'hEB,
  parameter logic [7:0]  CMD_WR   = 8'h38
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDRBITS-1:0] wb_adr_i,
  input  logic [DATABITS-1:0] wb_dat_i,
  output logic [DATABITS-1:0] wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_stall_o,
  output logic                wb_err_o,
  output logic                spi_sck_o,
  output logic                spi_sce_o,
  output logic [3:0]          spi_io_o,
  output logic [3:0]          spi_io_oe,
  input  logic [3:0]          spi_io_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD, S_GAP
  } state_t;

  localparam logic [8:0] PH_LAST    = 9'(CLKDIV - 1);
  localparam logic [8:0] GAP_LAST   = 9'(2 * CLKDIV - 1);
  localparam logic [5:0] DUMMY_LAST = 6'(DUMMY - 1);

  state_t              state, state_n, seq_next;
  logic [8:0]          ph, ph_n;
  logic                hi, hi_n;
  logic [5:0]          cnt, cnt_n, last_cnt;
  logic                we_q, we_n;
  logic [31:0]         adr_q, adr_n;
  logic [DATABITS-1:0] wdat_q, wdat_n, rdat_q, rdat_n, dat_o_n;
  logic                drop_q, drop_n, ack_n;
  logic [7:0]          cmd_n;
  logic                sck_n, sce_n;
  logic [3:0]          io_n, oe_n;

  assign wb_err_o = 1'b0;

  // Length of the current SCK phase and the state that follows it.
  always_comb begin
    last_cnt = 6'd3;
    seq_next = S_HOLD;
    unique case (state)
      S_CMD: begin
        last_cnt = 6'd7;
        seq_next = S_ADDR;
      end
      S_ADDR: begin
        last_cnt = 6'd7;
        seq_next = (we_q || DUMMY == 0) ? S_DATA : S_DUMMY;
      end
      S_DUMMY: begin
        last_cnt = DUMMY_LAST;
        seq_next = S_DATA;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    ph_n    = ph;
    hi_n    = hi;
    cnt_n   = cnt;
    we_n    = we_q;
    adr_n   = adr_q;
    wdat_n  = wdat_q;
    rdat_n  = rdat_q;
    drop_n  = drop_q;
    ack_n   = 1'b0;
    dat_o_n = wb_dat_o;

    unique case (state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_n = S_CMD;
          ph_n    = '0;
          hi_n    = 1'b0;
          cnt_n   = '0;
          we_n    = wb_we_i;
          adr_n   = 32'(wb_adr_i);
          wdat_n  = wb_dat_i;
          drop_n  = 1'b0;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        if (ph == PH_LAST) begin
          ph_n = '0;
          if (!hi) begin
            hi_n = 1'b1;
            // This edge raises SCK: sample the slave's nibble.
            if (state == S_DATA && !we_q)
              rdat_n = {rdat_q[DATABITS-5:0], spi_io_i};
          end else begin
            hi_n = 1'b0;
            if (cnt == last_cnt) begin
              cnt_n   = '0;
              state_n = seq_next;
            end else begin
              cnt_n = cnt + 6'd1;
            end
          end
        end else begin
          ph_n = ph + 9'd1;
        end
      end
      S_HOLD: begin
        if (ph == PH_LAST) begin
          ph_n    = '0;
          state_n = S_GAP;
          ack_n   = wb_cyc_i && !drop_q;
          if (!we_q) dat_o_n = rdat_q;
        end else begin
          ph_n = ph + 9'd1;
        end
      end
      S_GAP: begin
        if (ph == GAP_LAST) begin
          ph_n    = '0;
          state_n = S_IDLE;
        end else begin
          ph_n = ph + 9'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A master that drops CYC abandons the access; the frame still finishes.
    if (state != S_IDLE && !wb_cyc_i) drop_n = 1'b1;
  end

  // Pin values are decoded from the next state so the registered pins
  // always match the state the FSM is in during that cycle.
  always_comb begin
    sce_n = 1'b1;
    sck_n = 1'b0;
    io_n  = '0;
    oe_n  = '0;
    cmd_n = we_n ? CMD_WR : CMD_RD;
    unique case (state_n)
      S_CMD: begin
        sce_n = 1'b0;
        sck_n = hi_n;
        io_n  = {3'b000, cmd_n[~cnt_n[2:0]]};
        oe_n  = 4'b0001;
      end
      S_ADDR: begin
        sce_n = 1'b0;
        sck_n = hi_n;
        io_n  = 4'(adr_n >> {~cnt_n[2:0], 2'b00});
        oe_n  = 4'hF;
      end
      S_DUMMY: begin
        sce_n = 1'b0;
        sck_n = hi_n;
      end
      S_DATA: begin
        sce_n = 1'b0;
        sck_n = hi_n;
        if (we_n) begin
          io_n = 4'(wdat_n >> {~cnt_n[1:0], 2'b00});
          oe_n = 4'hF;
        end
      end
      S_HOLD: sce_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      ph         <= '0;
      hi         <= 1'b0;
      cnt        <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      drop_q     <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_stall_o <= 1'b0;
      wb_dat_o   <= '0;
      spi_sck_o  <= 1'b0;
      spi_sce_o  <= 1'b1;
      spi_io_o   <= '0;
      spi_io_oe  <= '0;
    end else begin
      state      <= state_n;
      ph         <= ph_n;
      hi         <= hi_n;
      cnt        <= cnt_n;
      we_q       <= we_n;
      adr_q      <= adr_n;
      wdat_q     <= wdat_n;
      rdat_q     <= rdat_n;
      drop_q     <= drop_n;
      wb_ack_o   <= ack_n;
      wb_stall_o <= (state_n != S_IDLE);
      wb_dat_o   <= dat_o_n;
      spi_sck_o  <= sck_n;
      spi_sce_o  <= sce_n;
      spi_io_o   <= io_n;
      spi_io_oe  <= oe_n;
    end
  end

endmodule

// File: tb/tb_qspi_host_master.sv
// Bench for qspi_host_master: three instances cover CLKDIV=1/DUMMY=4,
// CLKDIV=2/DUMMY=4 and CLKDIV=1/DUMMY=0. Expected per-SCK-rise lane values
// and read words are queued when a request is issued and consumed as the
// frame is observed.
module tb_qspi_host_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic        cyc_a [3], stb_a [3], we_a [3];
  logic        ack_a [3], stall_a [3], err_a [3], sck_a [3], sce_a [3];
  logic [25:0] adr_a [3];
  logic [15:0] dati_a [3], dato_a [3];
  logic [3:0]  io_a [3], oe_a [3], ioi_a [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    qspi_host_master #(
      .ADDRBITS(26), .DATABITS(16),
      .CLKDIV((g == 1) ? 2 : 1), .DUMMY((g == 2) ? 0 : 4),
      .CMD_RD(8'hEB), .CMD_WR(8'h38)
    ) u_dut (
      .clk_i(clk), .reset_i(reset),
      .wb_cyc_i(cyc_a[g]), .wb_stb_i(stb_a[g]), .wb_we_i(we_a[g]),
      .wb_adr_i(adr_a[g]), .wb_dat_i(dati_a[g]), .wb_dat_o(dato_a[g]),
      .wb_ack_o(ack_a[g]), .wb_stall_o(stall_a[g]), .wb_err_o(err_a[g]),
      .spi_sck_o(sck_a[g]), .spi_sce_o(sce_a[g]),
      .spi_io_o(io_a[g]), .spi_io_oe(oe_a[g]), .spi_io_i(ioi_a[g])
    );
  end

  function automatic int cdv(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int dmy(input int i);
    return (i == 2) ? 0 : 4;
  endfunction

  int          nvec = 0;
  int          nerr = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] slave_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {oe, io} at every SCK rise of one frame, plus the read word.
  task automatic push_exp(input int i, input logic we, input logic [25:0] adr,
                          input logic [15:0] dat);
    logic [7:0]  cmd;
    logic [31:0] a32;
    cmd = we ? 8'h38 : 8'hEB;
    a32 = {6'b0, adr};
    for (int j = 0; j < 8; j++) exp_q.push_back({4'b0001, 3'b000, cmd[7-j]});
    for (int j = 0; j < 8; j++) exp_q.push_back({4'hF, a32[31-4*j -: 4]});
    if (!we) for (int j = 0; j < dmy(i); j++) exp_q.push_back(8'h00);
    for (int j = 0; j < 4; j++) exp_q.push_back(we ? {4'hF, dat[15-4*j -: 4]} : 8'h00);
    if (!we) rd_q.push_back(slave_word);
  endtask

  // Issue one request on instance i and follow the frame to completion.
  // drop_at / abort_at: SCK rise count at which CYC is dropped / reset pulsed.
  task automatic txn(input int i, input logic we, input logic [25:0] adr,
                     input logic [15:0] dat, input logic keep_stb,
                     input int drop_at, input int abort_at,
                     output int t0, output int tack);
    int         n, rises, nack, k;
    logic       prev, done, aborted;
    logic [7:0] e;
    cyc_a[i] = 1'b1; stb_a[i] = 1'b1; we_a[i] = we; adr_a[i] = adr; dati_a[i] = dat;
    push_exp(i, we, adr, dat);
    n = 20 + (we ? 0 : dmy(i));
    t0 = -1; tack = -1;
    for (int c = 0; c < 200; c++) begin
      if (!stall_a[i]) begin
        t0 = cyc_n;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("inst%0d accept", i), (t0 >= 0), 1);
    @(negedge clk);
    if (!keep_stb) stb_a[i] = 1'b0;
    chk($sformatf("inst%0d ce_sck_stall@T0+1", i), {sce_a[i], sck_a[i], stall_a[i]}, 3'b001);
    rises = 0; nack = 0; prev = 1'b0; done = 1'b0; aborted = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (sck_a[i] && !prev) begin
        rises++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("inst%0d rise%0d oe_io", i, rises), {oe_a[i], io_a[i]}, e);
        end else begin
          chk($sformatf("inst%0d extra_sck", i), rises, n);
        end
      end
      prev = sck_a[i];
      k = rises - 16 - dmy(i);
      if (k < 0) k = 0;
      if (k > 3) k = 3;
      ioi_a[i] = 4'(slave_word >> (12 - 4 * k));
      if (ack_a[i]) begin
        nack++;
        tack = cyc_n;
        chk($sformatf("inst%0d ce_sck@ack", i), {sce_a[i], sck_a[i]}, 2'b10);
        if (!we && rd_q.size() > 0) chk($sformatf("inst%0d rdata", i), dato_a[i], rd_q.pop_front());
      end
      if (rises == drop_at) begin
        cyc_a[i] = 1'b0; stb_a[i] = 1'b0;
      end
      if (rises == abort_at) begin
        cyc_a[i] = 1'b0; stb_a[i] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk($sformatf("inst%0d reset_outputs", i),
            {ack_a[i], stall_a[i], sck_a[i], sce_a[i], oe_a[i], io_a[i]},
            {1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0});
        aborted = 1'b1; done = 1'b1;
        break;
      end
      if (c > 0 && !stall_a[i]) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("inst%0d frame_done", i), done, 1);
    if (aborted) begin
      exp_q.delete();
      rd_q.delete();
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (ack_a[i]) nack++;
      end
      chk($sformatf("inst%0d no_ack_after_reset", i), nack, 0);
    end else begin
      chk($sformatf("inst%0d sck_count", i), rises, n);
      if (drop_at >= 0) begin
        chk($sformatf("inst%0d no_ack_on_drop", i), nack, 0);
        if (rd_q.size() > 0) void'(rd_q.pop_front());
        cyc_a[i] = 1'b0;
      end else begin
        chk($sformatf("inst%0d ack_count", i), nack, 1);
        chk($sformatf("inst%0d ack_latency", i), tack - t0, 1 + 2 * n * cdv(i) + cdv(i));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, ta, t0b, tb;
    reset = 1'b1;
    slave_word = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      cyc_a[i] = 1'b0; stb_a[i] = 1'b0; we_a[i] = 1'b0;
      adr_a[i] = '0; dati_a[i] = '0; ioi_a[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("inst%0d reset_state", i),
          {ack_a[i], stall_a[i], sck_a[i], sce_a[i], oe_a[i], io_a[i], dato_a[i], err_a[i]},
          {1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 16'h0000, 1'b0});
    reset = 1'b0;
    @(negedge clk);

    // Read, CLKDIV=1, DUMMY=4: ack at T0+50.
    slave_word = 16'hBEEF;
    txn(0, 1'b0, 26'h0123456, 16'h0000, 1'b0, -1, -1, t0, ta);
    repeat (2) @(negedge clk);

    // Write, CLKDIV=2: no dummy phase, ack at T0+83.
    txn(1, 1'b1, 26'h3FFFFFF, 16'hA55A, 1'b0, -1, -1, t0, ta);
    repeat (2) @(negedge clk);

    // Read with DUMMY=0, CLKDIV=1: ack at T0+42.
    slave_word = 16'hC3A5;
    txn(2, 1'b0, 26'h0000ABC, 16'h0000, 1'b0, -1, -1, t0, ta);
    repeat (2) @(negedge clk);

    // Back-to-back reads with STB held.
    slave_word = 16'h5A0F;
    txn(0, 1'b0, 26'h1555555, 16'h0000, 1'b1, -1, -1, t0, ta);
    slave_word = 16'h9876;
    txn(0, 1'b0, 26'h2AAAAAA, 16'h0000, 1'b0, -1, -1, t0b, tb);
    chk("b2b accept_gap", t0b - ta, 2 * cdv(0));
    chk("b2b ce_high_time", ((t0b + 1 - ta) >= 2 * cdv(0)), 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of ADDR, then a normal read.
    slave_word = 16'h1111;
    txn(0, 1'b0, 26'h0ABCDEF, 16'h0000, 1'b0, -1, 10, t0, ta);
    slave_word = 16'h0F1E;
    txn(0, 1'b0, 26'h0000123, 16'h0000, 1'b0, -1, -1, t0, ta);
    repeat (2) @(negedge clk);

    // Drop CYC at the first DATA rise: full frame, no ack.
    slave_word = 16'h7777;
    txn(0, 1'b0, 26'h0000777, 16'h0000, 1'b0, 21, -1, t0, ta);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
